// File: rtl/pipe_pkg.sv
// Shared opcode constants, controller state encoding and instruction field layout.
package pipe_pkg;

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam logic [31:0] NOP_INST = 32'h0;

   typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

   // Upper 20 bits of an instruction, in bit order opcode/rd/rs/rt
   typedef struct packed {
      logic [4:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
   } fields_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational decode of the F/D instruction and load-use compare against D/X.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [31:0] fd_inst,
   input  logic [4:0]  dx_rd,
   input  logic        dx_is_load,
   output logic        load_use
);

   fields_t    f;
   logic       use_rs, use_rt, use_rd;
   logic [11:0] unused_bits;

   assign f           = fields_t'(fd_inst[31:12]);
   assign unused_bits = fd_inst[11:0];

   // Which fields the F/D instruction reads, then compare with the pending load target
   always_comb begin
      use_rs   = !(f.opcode inside {OP_J, OP_JAL, OP_SETX, OP_BEX});
      use_rt   = (f.opcode == OP_R);
      // stores and register-compare branches read rd as a source
      use_rd   = f.opcode inside {OP_SW, OP_BNE, OP_BLT, OP_JR};
      load_use = dx_is_load && (dx_rd != 5'd0) &&
                 ((use_rs && (f.rs == dx_rd)) ||
                  (use_rt && (f.rt == dx_rd)) ||
                  (use_rd && (f.rd == dx_rd)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes,
// multdiv stall with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      fd_inst,
   input  logic [4:0]       dx_rd,
   input  logic             dx_is_load,
   input  logic             x_branch_taken,
   input  logic             md_start,
   input  logic             md_ready,
   output logic             pc_en,
   output logic             fd_en,
   output logic             fd_nop,
   output logic             dx_en,
   output logic             dx_nop,
   output logic             xm_nop,
   output logic             md_busy,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   // +1 keeps the width non-zero for tiny timeouts
   localparam int WC_W = $clog2(MD_TIMEOUT + 1);

   state_t          state;
   logic [WC_W-1:0] wait_cnt;
   logic            load_use;
   logic            md_release;
   logic            md_expired;

   hazard_detect u_hazard (
      .fd_inst    (fd_inst),
      .dx_rd      (dx_rd),
      .dx_is_load (dx_is_load),
      .load_use   (load_use)
   );

   assign md_expired = (wait_cnt == WC_W'(MD_TIMEOUT - 1));

   // Enables and nops from current state and inputs; forced to defaults while in reset
   always_comb begin
      pc_en      = 1'b1;
      fd_en      = 1'b1;
      dx_en      = 1'b1;
      fd_nop     = 1'b0;
      dx_nop     = 1'b0;
      xm_nop     = 1'b0;
      md_busy    = 1'b0;
      md_release = 1'b0;
      if (reset) begin
         case (state)
            RUN: begin
               // md_start takes the cycle with defaults; a pending load-use is seen again after release
               if (md_start) begin
                  pc_en = 1'b1;
               end else if (x_branch_taken) begin
                  fd_nop = 1'b1;
                  dx_nop = 1'b1;
               end else if (load_use) begin
                  pc_en  = 1'b0;
                  fd_en  = 1'b0;
                  dx_nop = 1'b1;
               end
            end
            MD_WAIT: begin
               // release cycle (result or timeout) already runs with default controls
               md_release = md_ready || md_expired;
               if (!md_release) begin
                  pc_en   = 1'b0;
                  fd_en   = 1'b0;
                  dx_en   = 1'b0;
                  xm_nop  = 1'b1;
                  md_busy = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // State, multdiv wait counter, sticky timeout flag and saturating stall counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         wait_cnt   <= '0;
         md_timeout <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         if (!pc_en && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
         case (state)
            RUN: begin
               wait_cnt <= '0;
               if (md_start)
                  state <= MD_WAIT;
            end
            MD_WAIT: begin
               if (md_release) begin
                  state    <= RUN;
                  wait_cnt <= '0;
                  if (!md_ready)
                     md_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
